// File: rtl/matrix_keypad_scanner_pkg.sv
// Shared helpers for the keypad scanner: width calculation used to size
// counters, indices and the packed {release, code} event word.
package matrix_keypad_scanner_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Never returns zero so degenerate parameter values still give legal vectors.
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/matrix_keypad_scanner_event_fifo.sv
// Synchronous event FIFO; the head word is presented combinationally and
// a push into a full queue is accepted only when a pop frees a slot.
module matrix_keypad_scanner_event_fifo
    import matrix_keypad_scanner_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = width_of(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// ROWS x COLS keypad scanner: column drive, per-key debounce and a
// press/release event queue with valid/ready handshake.
module matrix_keypad_scanner
    import matrix_keypad_scanner_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int REPORT_RELEASE = 1,
    localparam int KEY_W         = width_of(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS-1:0]      row_n,
    output logic [COLS-1:0]      col_n,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KEY_W-1:0]     evt_code,
    output logic                 evt_release,
    output logic [ROWS*COLS-1:0] keys_down,
    output logic                 overflow,
    input  logic                 clear_overflow
);
    localparam int NKEYS = ROWS * COLS;
    localparam int EVT_W = KEY_W + 1;
    localparam int PRE_W = width_of(SCAN_DIV);
    localparam int COL_W = width_of(COLS);
    localparam int CNT_W = width_of(DEBOUNCE_SCANS);
    localparam int ROW_W = width_of(ROWS);

    logic [ROWS-1:0]  row_meta_q, row_sync_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             sample;
    logic [NKEYS-1:0] keys_q, flip;
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [ROWS-1:0]  pend_q, pend_d, pend_rel_q, pend_rel_d;
    logic [ROWS-1:0]  new_bits, new_rel, take;
    logic [ROW_W-1:0] take_row;
    logic [COL_W-1:0] pend_col_q, pend_col_d;
    logic             push_req, drop;
    logic [EVT_W-1:0] push_data, head;
    logic             fifo_full, fifo_empty;
    logic             overflow_q, overflow_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    assign sample = enable && (presc_q == PRE_W'(SCAN_DIV - 1));

    // Disabling parks the prescaler at 0 so a re-enable starts a full dwell.
    always_comb begin
        presc_d = presc_q;
        col_d   = col_q;
        if (!enable) begin
            presc_d = '0;
        end else if (sample) begin
            presc_d = '0;
            col_d   = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Columns float high while disabled and while reset is held.
    assign col_n = (enable && reset) ? ~(COLS'(1) << col_q) : '1;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
            localparam int KC = gi / ROWS;
            localparam int KR = gi % ROWS;
            logic hit, s;
            assign hit      = sample && (col_q == COL_W'(KC));
            assign s        = ~row_sync_q[KR];
            assign flip[gi] = hit && (s != keys_q[gi]) &&
                              (cnt_q[gi] == CNT_W'(DEBOUNCE_SCANS - 1));
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q[gi]  <= '0;
                    keys_q[gi] <= 1'b0;
                end else if (hit) begin
                    if (s == keys_q[gi]) begin
                        cnt_q[gi] <= '0;
                    end else if (flip[gi]) begin
                        cnt_q[gi]  <= '0;
                        keys_q[gi] <= ~keys_q[gi];
                    end else begin
                        cnt_q[gi] <= cnt_q[gi] + 1'b1;
                    end
                end
            end
        end

        // Only the sampled column can flip, so OR-ing across columns picks it out.
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] ev_col, rel_col;
            for (genvar gj = 0; gj < COLS; gj++) begin : g_col
                assign ev_col[gj]  = flip[gj*ROWS+gi] &&
                                     ((REPORT_RELEASE != 0) || !keys_q[gj*ROWS+gi]);
                assign rel_col[gj] = flip[gj*ROWS+gi] && keys_q[gj*ROWS+gi];
            end
            assign new_bits[gi] = |ev_col;
            assign new_rel[gi]  = |rel_col;
        end
    endgenerate

    always_comb begin
        take     = '0;
        take_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (pend_q[r]) begin
                take     = ROWS'(1) << r;
                take_row = ROW_W'(r);
            end
        end
    end

    assign push_req  = enable && (|pend_q);
    assign push_data = {|(pend_rel_q & take),
                        KEY_W'(pend_col_q) * KEY_W'(ROWS) + KEY_W'(take_row)};

    always_comb begin
        pend_d     = pend_q;
        pend_rel_d = pend_rel_q;
        pend_col_d = pend_col_q;
        if (enable) begin
            pend_d     = (pend_q & ~take) | new_bits;
            pend_rel_d = (pend_rel_q & ~new_bits) | (new_rel & new_bits);
            if (sample) pend_col_d = col_q;
        end
    end

    assign drop       = push_req && fifo_full && !evt_ready;
    assign overflow_d = (overflow_q && !clear_overflow) || drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            col_q      <= '0;
            pend_q     <= '0;
            pend_rel_q <= '0;
            pend_col_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            col_q      <= col_d;
            pend_q     <= pend_d;
            pend_rel_q <= pend_rel_d;
            pend_col_q <= pend_col_d;
            overflow_q <= overflow_d;
        end
    end

    matrix_keypad_scanner_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (reset),
        .push_i      (push_req),
        .push_data_i (push_data),
        .pop_i       (evt_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign evt_valid   = !fifo_empty;
    assign evt_code    = fifo_empty ? '0 : head[KEY_W-1:0];
    assign evt_release = fifo_empty ? 1'b0 : head[EVT_W-1];
    assign keys_down   = keys_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for the keypad scanner with a behavioural 4x4 key matrix.
module tb_matrix_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_code;
    logic        evt_release;
    logic [15:0] keys_down;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .FIFO_DEPTH(4), .REPORT_RELEASE(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .row_n          (row_n),
        .col_n          (col_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_release    (evt_release),
        .keys_down      (keys_down),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_n = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
    end

    task automatic wait_valid(input int limit, output bit ok);
        int i;
        i = 0;
        while (evt_valid !== 1'b1 && i < limit) begin
            @(negedge clk);
            i++;
        end
        ok = (evt_valid === 1'b1);
    endtask

    task automatic wait_col(input logic [3:0] pat);
        int i;
        i = 0;
        while (col_n !== pat && i < 64) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic pop_head();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1111) begin n_fail++; $display("FAIL reset_col: col_n=%b required 1111", col_n); end
        n_checks++;
        if (evt_valid !== 1'b0 || evt_code !== 4'd0 || evt_release !== 1'b0) begin
            n_fail++; $display("FAIL reset_evt: valid=%b code=%0d rel=%b required 0 0 0", evt_valid, evt_code, evt_release);
        end
        n_checks++;
        if (keys_down !== 16'h0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: keys=%h ovf=%b required 0000 0", keys_down, overflow);
        end
        $display("reset: col_n=%b valid=%b keys=%h", col_n, evt_valid, keys_down);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan();
        logic [3:0] exp_col [4];
        int bad;
        exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bad = 0;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if (col_n !== exp_col[i/4]) begin
                n_fail++; bad++;
                $display("FAIL scan_col[%0d]: col_n=%b required %b", i, col_n, exp_col[i/4]);
            end
            @(negedge clk);
        end
        $display("scan: 16 column samples, %0d wrong", bad);
    endtask

    task automatic test_press_release();
        bit ok;
        pressed[9] = 1'b1;
        wait_valid(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL press9_timeout: valid=%b required 1", evt_valid); end
        n_checks++;
        if (evt_code !== 4'd9 || evt_release !== 1'b0) begin
            n_fail++; $display("FAIL press9_evt: code=%0d rel=%b required 9 0", evt_code, evt_release);
        end
        n_checks++;
        if (keys_down !== 16'h0200) begin n_fail++; $display("FAIL press9_keys: keys=%h required 0200", keys_down); end
        $display("press: code=%0d rel=%b keys=%h", evt_code, evt_release, keys_down);
        pop_head();
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL press9_single: valid=%b required 0", evt_valid); end
        pressed[9] = 1'b0;
        wait_valid(100, ok);
        n_checks++;
        if (!ok || evt_code !== 4'd9 || evt_release !== 1'b1) begin
            n_fail++; $display("FAIL release9_evt: valid=%b code=%0d rel=%b required 1 9 1", evt_valid, evt_code, evt_release);
        end
        n_checks++;
        if (keys_down !== 16'h0) begin n_fail++; $display("FAIL release9_keys: keys=%h required 0000", keys_down); end
        $display("release: code=%0d rel=%b keys=%h", evt_code, evt_release, keys_down);
        pop_head();
    endtask

    task automatic test_glitch();
        wait_col(4'b0111);
        pressed[9] = 1'b1;
        repeat (16) @(negedge clk);
        pressed[9] = 1'b0;
        repeat (64) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b0 || keys_down !== 16'h0) begin
            n_fail++; $display("FAIL glitch: valid=%b keys=%h required 0 0000", evt_valid, keys_down);
        end
        $display("glitch: valid=%b keys=%h", evt_valid, keys_down);
    endtask

    task automatic test_overflow();
        logic [3:0] order [5];
        order = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd3};
        for (int i = 0; i < 5; i++) begin
            pressed[order[i]] = 1'b1;
            repeat (64) @(negedge clk);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: overflow=%b required 1", overflow); end
        n_checks++;
        if (keys_down !== 16'h8429) begin n_fail++; $display("FAIL ovf_keys: keys=%h required 8429", keys_down); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (evt_valid !== 1'b1 || evt_code !== order[i] || evt_release !== 1'b0) begin
                n_fail++; $display("FAIL ovf_drain[%0d]: valid=%b code=%0d rel=%b required 1 %0d 0", i, evt_valid, evt_code, evt_release, order[i]);
            end
            $display("drain: code=%0d rel=%b", evt_code, evt_release);
            pop_head();
        end
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: valid=%b required 0", evt_valid); end
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: overflow=%b required 0", overflow); end
        pressed = '0;
        evt_ready = 1'b1;
        repeat (80) @(negedge clk);
        evt_ready = 1'b0;
        n_checks++;
        if (keys_down !== 16'h0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_flush: keys=%h valid=%b ovf=%b required 0000 0 0", keys_down, evt_valid, overflow);
        end
        $display("overflow: cleared, keys=%h", keys_down);
    endtask

    task automatic test_back_to_back();
        bit ok;
        evt_ready = 1'b1;
        pressed[4] = 1'b1;
        pressed[7] = 1'b1;
        wait_valid(100, ok);
        n_checks++;
        if (!ok || evt_code !== 4'd4 || evt_release !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: valid=%b code=%0d rel=%b required 1 4 0", evt_valid, evt_code, evt_release);
        end
        $display("b2b: code=%0d", evt_code);
        @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b1 || evt_code !== 4'd7 || evt_release !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: valid=%b code=%0d rel=%b required 1 7 0", evt_valid, evt_code, evt_release);
        end
        $display("b2b: code=%0d", evt_code);
        @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: valid=%b required 0", evt_valid); end
        pressed = '0;
        repeat (80) @(negedge clk);
        evt_ready = 1'b0;
        n_checks++;
        if (keys_down !== 16'h0 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_release: keys=%h valid=%b required 0000 0", keys_down, evt_valid);
        end
    endtask

    task automatic test_enable_freeze();
        bit ok;
        int seen;
        int guard;
        logic [3:0] prev;
        wait_col(4'b0111);
        pressed[9] = 1'b1;
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 100) begin
            prev = col_n;
            @(negedge clk);
            guard++;
            if (prev == 4'b1011 && col_n == 4'b0111) seen++;
        end
        n_checks++;
        if (seen != 2) begin n_fail++; $display("FAIL freeze_setup: col2 samples=%0d required 2", seen); end
        enable = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1111 || keys_down !== 16'h0 || evt_valid !== 1'b0) begin
            n_fail++; $display("FAIL freeze_hold: col_n=%b keys=%h valid=%b required 1111 0000 0", col_n, keys_down, evt_valid);
        end
        enable = 1'b1;
        wait_valid(24, ok);
        n_checks++;
        if (!ok || evt_code !== 4'd9 || evt_release !== 1'b0) begin
            n_fail++; $display("FAIL freeze_resume: valid=%b code=%0d rel=%b required 1 9 0", evt_valid, evt_code, evt_release);
        end
        $display("resume: code=%0d keys=%h", evt_code, keys_down);
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0 || keys_down !== 16'h0) begin
            n_fail++; $display("FAIL midreset_state: valid=%b keys=%h required 0 0000", evt_valid, keys_down);
        end
        n_checks++;
        if (col_n !== 4'b1111 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out: col_n=%b ovf=%b required 1111 0", col_n, overflow);
        end
        $display("mid-reset: valid=%b keys=%h col_n=%b", evt_valid, keys_down, col_n);
        pressed = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press_release();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_enable_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
